// File: rtl/bcd_addsub_pipe_pkg.sv
// Shared BCD constants and digit helpers for the pipelined decimal adder/subtractor.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  function automatic logic [DIGIT_W-1:0] nines_comp(input logic [DIGIT_W-1:0] d);
    return BCD_MAX - d;
  endfunction

  function automatic logic digit_valid(input logic [DIGIT_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_addsub_pipe_if.sv
// Operand/result handshake bundle for bcd_addsub_pipe.
interface bcd_addsub_pipe_if
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DIGIT_W*DIGITS-1:0] x;
  logic [DIGIT_W*DIGITS-1:0] y;
  logic                      cin;
  logic                      sub;
  logic                      out_valid;
  logic                      out_ready;
  logic [DIGIT_W*DIGITS-1:0] sum;
  logic                      cout;
  logic                      err;

  modport slave (
    input  in_valid, x, y, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, err
  );

  modport master (
    output in_valid, x, y, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, err
  );
endinterface

// File: rtl/bcd_digit_cell.sv
// One-digit BCD add with decimal adjust; subtract is handled upstream by nine's complement.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_a,
  input  logic [DIGIT_W-1:0] i_b,
  input  logic               i_c,
  output logic [DIGIT_W-1:0] o_s,
  output logic               o_c
);
  logic [DIGIT_W:0] w_raw;

  always_comb begin
    w_raw = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT_W{1'b0}}, i_c};
    if (w_raw > {1'b0, BCD_MAX}) begin
      o_s = w_raw[DIGIT_W-1:0] + 4'd6;
      o_c = 1'b1;
    end else begin
      o_s = w_raw[DIGIT_W-1:0];
      o_c = 1'b0;
    end
  end
endmodule

// File: rtl/bcd_addsub_pipe.sv
// Pipelined packed-BCD add/sub: each stage resolves DIG_PER_STAGE digits, operands and partial
// sums travel together so a beat's digits all emerge on the same cycle.
module bcd_addsub_pipe
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS        = 8,
  parameter int unsigned DIG_PER_STAGE = 2
) (
  input logic              clk,
  input logic              rst,
  bcd_addsub_pipe_if.slave bus
);
  localparam int unsigned STAGES = DIGITS / DIG_PER_STAGE;
  localparam int unsigned W      = DIGIT_W * DIGITS;

  if (DIGITS % DIG_PER_STAGE != 0) begin : g_param_check
    $error("DIGITS must be a multiple of DIG_PER_STAGE");
  end

  logic                            w_en;
  logic                            w_cin_eff;
  logic                            w_err0;
  logic [W-1:0]                    w_y_eff;
  logic [STAGES-1:0][W-1:0]        w_a, w_b, w_sum_in, w_sum_nxt;
  logic [STAGES-1:0]               w_c_in, w_c_out, w_v_in, w_e_in, w_s_in;
  logic [DIGITS-1:0][DIGIT_W-1:0]  w_dig;
  logic [DIGITS-1:0]               w_dc_in, w_dc_out;
  logic                            w_unused;

  logic [STAGES-1:0][W-1:0]        r_x, r_y, r_sum;
  logic [STAGES-1:0]               r_valid, r_carry, r_err, r_sub;

  // Single global stall: the whole pipe moves only when the output slot can drain.
  assign w_en         = !r_valid[STAGES-1] || bus.out_ready;
  assign bus.in_ready = w_en;
  assign w_cin_eff    = bus.sub ? !bus.cin : bus.cin;

  always_comb begin
    w_err0  = 1'b0;
    w_y_eff = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (!digit_valid(bus.x[d*DIGIT_W +: DIGIT_W]) || !digit_valid(bus.y[d*DIGIT_W +: DIGIT_W])) begin
        w_err0 = 1'b1;
      end
      w_y_eff[d*DIGIT_W +: DIGIT_W] = bus.sub ? nines_comp(bus.y[d*DIGIT_W +: DIGIT_W])
                                              : bus.y[d*DIGIT_W +: DIGIT_W];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_a[k]      = bus.x;
      assign w_b[k]      = w_y_eff;
      assign w_sum_in[k] = '0;
      assign w_c_in[k]   = w_cin_eff;
      assign w_v_in[k]   = bus.in_valid;
      assign w_e_in[k]   = w_err0;
      assign w_s_in[k]   = bus.sub;
    end else begin : g_next
      assign w_a[k]      = r_x[k-1];
      assign w_b[k]      = r_y[k-1];
      assign w_sum_in[k] = r_sum[k-1];
      assign w_c_in[k]   = r_carry[k-1];
      assign w_v_in[k]   = r_valid[k-1];
      assign w_e_in[k]   = r_err[k-1];
      assign w_s_in[k]   = r_sub[k-1];
    end

    assign w_c_out[k] = w_dc_out[(k+1)*DIG_PER_STAGE-1];

    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
      if (d / DIG_PER_STAGE == k) begin : g_cell
        bcd_digit_cell u_cell (
          .i_a (w_a[k][d*DIGIT_W +: DIGIT_W]),
          .i_b (w_b[k][d*DIGIT_W +: DIGIT_W]),
          .i_c (w_dc_in[d]),
          .o_s (w_dig[d]),
          .o_c (w_dc_out[d])
        );
        assign w_sum_nxt[k][d*DIGIT_W +: DIGIT_W] = w_dig[d];
        if (d % DIG_PER_STAGE == 0) begin : g_cin_stage
          assign w_dc_in[d] = w_c_in[k];
        end else begin : g_cin_ripple
          assign w_dc_in[d] = w_dc_out[d-1];
        end
      end else begin : g_pass
        assign w_sum_nxt[k][d*DIGIT_W +: DIGIT_W] = w_sum_in[k][d*DIGIT_W +: DIGIT_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_carry <= '0;
      r_err   <= '0;
      r_sub   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_sum   <= '0;
    end else if (w_en) begin
      r_valid <= w_v_in;
      r_carry <= w_c_out;
      r_err   <= w_e_in;
      r_sub   <= w_s_in;
      r_x     <= w_a;
      r_y     <= w_b;
      r_sum   <= w_sum_nxt;
    end
  end

  // Last-stage operand copies have no consumer; synthesis strips them.
  assign w_unused = ^{r_x[STAGES-1], r_y[STAGES-1]};

  assign bus.out_valid = r_valid[STAGES-1];
  assign bus.sum       = r_sum[STAGES-1];
  assign bus.cout      = r_carry[STAGES-1] ^ r_sub[STAGES-1];
  assign bus.err       = r_err[STAGES-1];
endmodule
